// File: rtl/vz_pkg.sv
// vz_pkg: shared VZ snapshot constants, upload FSM states and header/length helpers.
package vz_pkg;
  localparam logic [31:0] VZ_MAGIC = 32'h565A4630;
  localparam int VZ_HDR_LEN = 24;
  localparam int VZ_NAME_LEN = 17;
  localparam logic [7:0] VZ_TYPE_BASIC = 8'hF0;
  localparam logic [7:0] VZ_TYPE_BIN = 8'hF1;
  typedef enum logic [1:0] {IDLE, PTR, SERVE, FETCH} vz_up_state_t;
  // The name parameter is a right-justified string literal; strip leading NULs so char 0 is the first letter.
  function automatic logic [7:0] name_char(input logic [127:0] f, input int i);
    int n;
    n = 16;
    for (int j = 15; j >= 0; j--) if (n == j + 1 && f[8*j +: 8] == 8'h00) n = j;
    return (i >= 0 && i < n) ? f[8*(n-1-i) +: 8] : 8'h00;
  endfunction
  function automatic logic [15:0] vz_file_len(input logic [15:0] s, input logic [15:0] e);
    logic [16:0] t;
    t = (e > s) ? 17'(e - s) + 17'(VZ_HDR_LEN) : 17'(VZ_HDR_LEN);
    return t[16] ? 16'hFFFF : t[15:0];
  endfunction
endpackage

// File: rtl/vz_hdr_gen.sv
// vz_hdr_gen: combinational VZ header byte generator for offsets 0..23.
module vz_hdr_gen
  import vz_pkg::*;
#(
  parameter logic [127:0] FNAME = {80'h0, "MISTER"}
) (
  input  logic [4:0]  offset,
  input  logic [15:0] start,
  input  logic [7:0]  type_byte,
  output logic [7:0]  hdr_byte
);
  always_comb
    hdr_byte = offset < 5'd4 ? VZ_MAGIC[8*(3-int'(offset)) +: 8] :
               offset < 5'(4 + VZ_NAME_LEN) ? name_char(FNAME, int'(offset) - 4) :
               offset == 5'd21 ? type_byte :
               offset == 5'd22 ? start[7:0] :
               offset == 5'd23 ? start[15:8] : 8'h00;
endmodule

// File: rtl/vz_upload.sv
// vz_upload: streams a VZ snapshot of the BASIC program to the HPS ioctl upload channel.
// Define VZ_UPLOAD_BIN_EN to add bin_sel/bin_start/bin_end for raw binary snapshots.
module vz_upload
  import vz_pkg::*;
#(
  parameter logic [127:0] FNAME = {80'h0, "MISTER"},
  parameter logic [15:0] PTR_START = 16'h78A4,
  parameter logic [15:0] PTR_END = 16'h78F9
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [15:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
`ifdef VZ_UPLOAD_BIN_EN
  input  logic        bin_sel,
  input  logic [15:0] bin_start,
  input  logic [15:0] bin_end,
`endif
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [15:0] file_len,
  output logic        busy
);
  vz_up_state_t state, nxt;
  logic up, up_q, rise, gap, pend, rd_v, hit_hdr, hit_ram, bin_go;
  logic [1:0] cnt;
  logic [7:0] typ, end_lo, hdr;
  logic [15:0] start, faddr, pend_addr, rd_a, b_start, b_end;
`ifdef VZ_UPLOAD_BIN_EN
  assign bin_go = bin_sel;
  assign b_start = bin_start;
  assign b_end = bin_end;
`else
  assign bin_go = 1'b0;
  assign b_start = 16'h0000;
  assign b_end = 16'h0000;
`endif
  assign up = ioctl_upload && ioctl_index == 8'd1;
  assign rise = up && !up_q && !reset;
  // A strobe latched during PTR/FETCH is replayed here as if it had just arrived.
  assign rd_v = ioctl_rd || pend;
  assign rd_a = ioctl_rd ? ioctl_addr : pend_addr;
  assign hit_hdr = rd_a < 16'(VZ_HDR_LEN);
  assign hit_ram = !hit_hdr && rd_a < file_len;
  vz_hdr_gen #(.FNAME(FNAME)) u_hdr (.offset(rd_a[4:0]), .start(start), .type_byte(typ), .hdr_byte(hdr));
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = rise ? (bin_go ? SERVE : PTR) : IDLE;
      PTR:   nxt = mem_ack ? (!up ? IDLE : cnt == 2'd3 ? SERVE : PTR) : (!up && gap ? IDLE : PTR);
      SERVE: nxt = !up ? IDLE : (rd_v && hit_ram) ? FETCH : SERVE;
      FETCH: nxt = mem_ack ? (up ? SERVE : IDLE) : FETCH;
    endcase
  end
  // gap idles mem_req for one cycle between pointer reads so each is a distinct transaction.
  always_comb begin
    mem_req = (state == PTR && !gap) || state == FETCH;
    mem_addr = state == FETCH ? faddr :
               (state == PTR && !gap) ? (cnt[1] ? PTR_END : PTR_START) + 16'(cnt[0]) : 16'h0000;
    ioctl_wait = up && (state == PTR || state == FETCH || (state == SERVE && rd_v && hit_ram) ||
                        (state == IDLE && rise && !bin_go));
    busy = state != IDLE;
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      up_q <= 1'b0;
      gap <= 1'b0;
      pend <= 1'b0;
      pend_addr <= '0;
      cnt <= '0;
      typ <= '0;
      end_lo <= '0;
      start <= '0;
      faddr <= '0;
      file_len <= '0;
      ioctl_din <= '0;
    end else begin
      up_q <= up;
      gap <= state == PTR && mem_ack;
      pend <= (state == PTR || state == FETCH) && (pend || ioctl_rd);
      if ((state == PTR || state == FETCH) && ioctl_rd) pend_addr <= ioctl_addr;
      if (state == IDLE && rise) begin
        cnt <= '0;
        start <= bin_go ? b_start : 16'h0000;
        file_len <= bin_go ? vz_file_len(b_start, b_end) : 16'h0000;
        typ <= bin_go ? VZ_TYPE_BIN : VZ_TYPE_BASIC;
      end
      if (state == PTR && mem_ack) begin
        cnt <= cnt + 2'd1;
        if (cnt == 2'd0) start[7:0] <= mem_data;
        if (cnt == 2'd1) start[15:8] <= mem_data;
        if (cnt == 2'd2) end_lo <= mem_data;
        if (cnt == 2'd3) file_len <= vz_file_len(start, {mem_data, end_lo});
      end
      if (state == SERVE && up && rd_v) begin
        if (hit_hdr) ioctl_din <= hdr;
        else if (!hit_ram) ioctl_din <= 8'h00;
        else faddr <= start + rd_a - 16'(VZ_HDR_LEN);
      end
      if (state == FETCH && mem_ack) ioctl_din <= mem_data;
    end
endmodule

// File: tb/tb_vz_upload.sv
// tb_vz_upload: directed scoreboard bench for vz_upload with a latency-programmable RAM arbiter model.
module tb_vz_upload;
  logic clk_sys = 0, reset = 1, ioctl_upload = 0, ioctl_rd = 0, mem_ack = 0;
  logic [7:0] ioctl_index = 0, mem_data = 0, ioctl_din;
  logic [15:0] ioctl_addr = 0, mem_addr, file_len;
  logic ioctl_wait, mem_req, busy;
`ifdef VZ_UPLOAD_BIN_EN
  logic bin_sel = 0;
  logic [15:0] bin_start = 0, bin_end = 0;
`endif
  logic [7:0] ram [0:65535];
  logic [7:0] exp_q [$];
  int errors = 0, checks = 0, lat = 2, n_acks = 0, rcnt = 0;
  logic req_q = 0, ack_q = 0, early_drop = 0, addr_moved = 0;
  logic [15:0] addr_q = 0;

  vz_upload dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
`ifdef VZ_UPLOAD_BIN_EN
    .bin_sel(bin_sel), .bin_start(bin_start), .bin_end(bin_end),
`endif
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .file_len(file_len), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Arbiter: acks on the lat-th clock edge that sees mem_req, and watches the request handshake.
  always @(posedge clk_sys) begin
    if (!reset && req_q && !ack_q && !mem_req) early_drop <= 1;
    if (req_q && !ack_q && mem_req && mem_addr != addr_q) addr_moved <= 1;
    req_q <= mem_req;
    ack_q <= mem_ack;
    addr_q <= mem_addr;
    if (!mem_req || mem_ack) begin
      rcnt <= 0;
      mem_ack <= 0;
    end else if (rcnt + 1 >= lat) begin
      mem_ack <= 1;
      mem_data <= ram[mem_addr];
      n_acks <= n_acks + 1;
    end else rcnt <= rcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ioctl_wait && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    chk({tag, "_wait"}, 32'(ioctl_wait), 0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e, input string tag);
    logic [7:0] x;
    exp_q.push_back(e);
    @(negedge clk_sys);
    ioctl_rd = 1;
    ioctl_addr = a;
    @(negedge clk_sys);
    ioctl_rd = 0;
    wait_ready(tag);
    x = exp_q.pop_front();
    chk(tag, 32'(ioctl_din), 32'(x));
  endtask

  task automatic open_session(input string tag);
    @(negedge clk_sys);
    ioctl_index = 1;
    ioctl_upload = 1;
    @(negedge clk_sys);
    wait_ready(tag);
  endtask

  task automatic close_session(input string tag);
    int n = 0;
    @(negedge clk_sys);
    ioctl_upload = 0;
    while (busy && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic set_ptrs(input logic [15:0] s, input logic [15:0] e);
    ram[16'h78A4] = s[7:0];
    ram[16'h78A5] = s[15:8];
    ram[16'h78F9] = e[7:0];
    ram[16'h78FA] = e[15:8];
  endtask

  initial begin
    int base, n;
    logic [7:0] x;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    #12;
    chk("rst_din", 32'(ioctl_din), 0);
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_len", 32'(file_len), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk_sys);
    reset = 0;

    // Wrong slot index must not start a session.
    @(negedge clk_sys);
    ioctl_index = 2;
    ioctl_upload = 1;
    repeat (3) @(negedge clk_sys);
    chk("idx2_busy", 32'(busy), 0);
    ioctl_upload = 0;
    @(negedge clk_sys);

    set_ptrs(16'h7AE9, 16'h7B09);
    ram[16'h7AE9] = 8'h5A;
    ram[16'h7AEA] = 8'h11;
    ram[16'h7B08] = 8'hC3;
    base = n_acks;
    @(negedge clk_sys);
    ioctl_index = 1;
    ioctl_upload = 1;
    #1 chk("s1_wait_now", 32'(ioctl_wait), 1);
    @(negedge clk_sys);
    wait_ready("s1_open");
    chk("s1_reads", 32'(n_acks - base), 4);
    chk("s1_len", 32'(file_len), 56);
    chk("s1_busy", 32'(busy), 1);
    rd(0, 8'h56, "h0");
    rd(1, 8'h5A, "h1");
    rd(2, 8'h46, "h2");
    rd(3, 8'h30, "h3");
    rd(4, "M", "h4");
    rd(9, "R", "h9");
    rd(10, 8'h00, "h10");
    rd(20, 8'h00, "h20");
    rd(21, 8'hF0, "h21");
    rd(22, 8'hE9, "h22");
    rd(23, 8'h7A, "h23");

    // Program byte with lat=4: ack lands 5 clocks after the strobe, so wait spans 6 cycles.
    lat = 4;
    base = n_acks;
    exp_q.push_back(8'h5A);
    @(negedge clk_sys);
    ioctl_rd = 1;
    ioctl_addr = 24;
    #1 n = ioctl_wait ? 1 : 0;
    @(negedge clk_sys);
    ioctl_rd = 0;
    while (ioctl_wait && n < 50) begin
      n++;
      @(negedge clk_sys);
    end
    chk("p24_cycles", 32'(n), 32'(lat + 2));
    x = exp_q.pop_front();
    chk("p24", 32'(ioctl_din), 32'(x));
    rd(55, 8'hC3, "p55");
    chk("p_reads", 32'(n_acks - base), 2);
    rd(56, 8'h00, "past_end");
    rd(16'hFFFF, 8'h00, "past_max");
    chk("past_reads", 32'(n_acks - base), 2);

    // A strobe during FETCH is held and replayed once the fetch completes.
    lat = 6;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h56);
    @(negedge clk_sys);
    ioctl_rd = 1;
    ioctl_addr = 25;
    @(negedge clk_sys);
    ioctl_rd = 0;
    @(negedge clk_sys);
    ioctl_rd = 1;
    ioctl_addr = 0;
    @(negedge clk_sys);
    ioctl_rd = 0;
    wait_ready("pend");
    x = exp_q.pop_front();
    chk("pend_first", 32'(ioctl_din), 32'(x));
    @(negedge clk_sys);
    x = exp_q.pop_front();
    chk("pend_second", 32'(ioctl_din), 32'(x));
    close_session("s1");

    lat = 2;
    set_ptrs(16'h7AE9, 16'h7AE9);
    open_session("s2");
    chk("s2_len", 32'(file_len), 24);
    base = n_acks;
    rd(24, 8'h00, "s2_r24");
    chk("s2_reads", 32'(n_acks - base), 0);
    close_session("s2");

    set_ptrs(16'h7AE9, 16'h7000);
    open_session("s3");
    chk("s3_len", 32'(file_len), 24);
    close_session("s3");

    // Drop the session while a pointer read is outstanding.
    lat = 10;
    @(negedge clk_sys);
    ioctl_upload = 1;
    repeat (3) @(negedge clk_sys);
    chk("drop_req_before", 32'(mem_req), 1);
    ioctl_upload = 0;
    #1 chk("drop_wait", 32'(ioctl_wait), 0);
    @(negedge clk_sys);
    chk("drop_req_held", 32'(mem_req), 1);
    close_session("drop");
    chk("drop_req_after", 32'(mem_req), 0);

    // Asynchronous reset in the middle of a program-byte fetch.
    lat = 2;
    set_ptrs(16'h7AE9, 16'h7B09);
    open_session("s5");
    lat = 10;
    @(negedge clk_sys);
    ioctl_rd = 1;
    ioctl_addr = 24;
    @(negedge clk_sys);
    ioctl_rd = 0;
    @(negedge clk_sys);
    chk("mid_req", 32'(mem_req), 1);
    #2 reset = 1;
    #1;
    chk("ar_req", 32'(mem_req), 0);
    chk("ar_wait", 32'(ioctl_wait), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_len", 32'(file_len), 0);
    chk("ar_din", 32'(ioctl_din), 0);
    chk("ar_addr", 32'(mem_addr), 0);
    ioctl_upload = 0;
    @(negedge clk_sys);
    reset = 0;
    lat = 2;

`ifdef VZ_UPLOAD_BIN_EN
    bin_sel = 1;
    bin_start = 16'h8000;
    bin_end = 16'h8010;
    base = n_acks;
    open_session("bin");
    bin_sel = 0;
    chk("bin_len", 32'(file_len), 40);
    chk("bin_reads", 32'(n_acks - base), 0);
    rd(21, 8'hF1, "bin_h21");
    rd(22, 8'h00, "bin_h22");
    rd(23, 8'h80, "bin_h23");
    close_session("bin");
`endif

    chk("req_held", 32'(early_drop), 0);
    chk("addr_stable", 32'(addr_moved), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
